muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit for the SCCPU datapath. Executes the long
//  ops the single-cycle ALU does not: MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/muldiv_unit_pkg.sv | 10 +
 rtl/muldiv_unit_divider.sv | 38 +++
 rtl/muldiv_unit.sv | 102 ++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes and FSM state encoding shared by the multiply/divide unit
package muldiv_unit_pkg;
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
endpackage

// File: rtl/muldiv_unit_divider.sv
// mdu_divider: restoring division, one quotient bit per step on unsigned magnitudes
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    assign sh   = {rem, quo[WIDTH-1]};
    assign ge   = sh >= {1'b0, dvs};
    // when ge holds the true difference is below the divisor, so the low bits suffice
    assign diff = sh[WIDTH-1:0] - dvs;
    assign dz   = dvs == '0;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (step) begin
            rem <= ge ? diff : sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   mcand, mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     sum;
    logic               go, op_signed, div_q, neg_q, rneg_q, dz;

    assign go        = state == S_IDLE && start;
    assign busy      = state != S_IDLE;
    assign op_signed = MDUOp == MDU_MULT || MDUOp == MDU_DIV;
    assign mag_a     = op_signed && A[WIDTH-1] ? -A : A;
    assign mag_b     = op_signed && B[WIDTH-1] ? -B : B;
    // shift-add: multiplier sits in acc low half and is consumed LSB-first
    assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : '0};
    assign prod      = neg_q ? -acc : acc;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk(clk),
        .rstn(rstn),
        .load(go && MDUOp[2:1] == 2'b01),
        .step(state == S_DIV),
        .dividend(mag_a),
        .divisor(mag_b),
        .quo(quo),
        .rem(rem),
        .dz(dz)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:       if (go && !MDUOp[2]) nxt = MDUOp[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (cnt == LAST) nxt = S_FIX;
            default:      nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            if (go && !MDUOp[2]) begin
                cnt    <= '0;
                div_q  <= MDUOp[1];
                neg_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                rneg_q <= op_signed && A[WIDTH-1];
                acc    <= {{WIDTH{1'b0}}, mag_b};
                mcand  <= mag_a;
            end
            if (go && MDUOp == MDU_MTHI) begin
                HI   <= A;
                done <= 1'b1;
            end
            if (go && MDUOp == MDU_MTLO) begin
                LO   <= A;
                done <= 1'b1;
            end
            if (state == S_MUL) acc <= {sum, acc[WIDTH-1:1]};
            if (state == S_MUL || state == S_DIV) cnt <= cnt + 1'b1;
            // divide by zero keeps the natural remainder (=A) but forces an all-ones quotient
            if (state == S_FIX) begin
                done <= 1'b1;
                HI   <= div_q ? (rneg_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
                LO   <= div_q ? (dz ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        string       name;
    } vec_t;

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [2:0]  MDUOp = 3'b0;
    logic [31:0] A = '0, B = '0;
    logic        busy, done;
    logic [31:0] HI, LO;
    int          checks = 0, failures = 0;

    vec_t mul_v[3] = '{
        '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"},
        '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"},
        '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"}
    };
    vec_t div_v[6] = '{
        '{MDU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"},
        '{MDU_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        "divu"},
        '{MDU_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negb"},
        '{MDU_DIVU, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "divu_zero"},
        '{MDU_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero"},
        '{MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"}
    };

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rstn(rstn), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    // issues an op in the current (negedge) cycle; lat counts cycles after the start edge until done
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic b0);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        b0 = busy;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_flags busy/done=%b exp=00", {busy, done}); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL reset_hilo HI=%h LO=%h exp=0/0", HI, LO); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat; logic b0;
        foreach (mul_v[i]) begin
            do_op(mul_v[i].op, mul_v[i].a, mul_v[i].b, lat, b0);
            checks++; if (lat !== 33) begin failures++; $display("FAIL %s_lat got=%0d exp=33", mul_v[i].name, lat); end
            checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", mul_v[i].name, b0); end
            checks++; if (HI !== mul_v[i].hi || LO !== mul_v[i].lo) begin failures++; $display("FAIL %s HI=%h LO=%h exp=%h/%h", mul_v[i].name, HI, LO, mul_v[i].hi, mul_v[i].lo); end
        end
    endtask

    task automatic test_div();
        int lat; logic b0;
        foreach (div_v[i]) begin
            do_op(div_v[i].op, div_v[i].a, div_v[i].b, lat, b0);
            checks++; if (lat !== 33) begin failures++; $display("FAIL %s_lat got=%0d exp=33", div_v[i].name, lat); end
            checks++; if (HI !== div_v[i].hi || LO !== div_v[i].lo) begin failures++; $display("FAIL %s HI=%h LO=%h exp=%h/%h", div_v[i].name, HI, LO, div_v[i].hi, div_v[i].lo); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat; logic b0;
        do_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, lat, b0);
        checks++; if (lat !== 0 || b0 !== 1'b0) begin failures++; $display("FAIL mthi_timing lat=%0d busy=%b exp=0/0", lat, b0); end
        checks++; if (HI !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_val HI=%h exp=deadbeef", HI); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_pulse done=%b exp=0", done); end
        do_op(MDU_MTLO, 32'd5, 32'd0, lat, b0);
        checks++; if (lat !== 0 || b0 !== 1'b0) begin failures++; $display("FAIL mtlo_timing lat=%0d busy=%b exp=0/0", lat, b0); end
        checks++; if (LO !== 32'd5 || HI !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mtlo_val HI=%h LO=%h exp=deadbeef/5", HI, LO); end
        @(negedge clk);
    endtask

    task automatic test_unknown();
        start = 1'b1; MDUOp = 3'b111; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL unknown_flags busy/done=%b exp=00", {busy, done}); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || HI !== 32'hDEAD_BEEF || LO !== 32'd5) begin failures++; $display("FAIL unknown_hold done=%b HI=%h LO=%h exp=0/deadbeef/5", done, HI, LO); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        start = 1'b1; MDUOp = MDU_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == 10) begin start = 1'b1; MDUOp = MDU_DIVU; A = 32'd100; B = 32'd3; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_lat got=%0d exp=33", lat); end
        checks++; if (HI !== 32'd0 || LO !== 32'd42) begin failures++; $display("FAIL ignore_val HI=%h LO=%h exp=0/2a", HI, LO); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL ignore_after busy/done=%b exp=00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b0;
        do_op(MDU_MULTU, 32'd3, 32'd5, lat, b0);
        checks++; if (lat !== 33 || LO !== 32'd15 || HI !== 32'd0) begin failures++; $display("FAIL b2b_first lat=%0d HI=%h LO=%h exp=33/0/f", lat, HI, LO); end
        do_op(MDU_DIVU, 32'd100, 32'd7, lat, b0);
        checks++; if (b0 !== 1'b1 || lat !== 33) begin failures++; $display("FAIL b2b_accept busy=%b lat=%0d exp=1/33", b0, lat); end
        checks++; if (HI !== 32'd2 || LO !== 32'd14) begin failures++; $display("FAIL b2b_second HI=%h LO=%h exp=2/e", HI, LO); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start = 1'b1; MDUOp = MDU_DIV; A = 32'hFFFF_FFF9; B = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rstmid_flags busy/done=%b exp=00", {busy, done}); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL rstmid_hilo HI=%h LO=%h exp=0/0", HI, LO); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0 || HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL rstmid_abort activity=%0d HI=%h LO=%h exp=0/0/0", seen, HI, LO); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_unknown();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
